// File: rtl/irq_ctrl_pkg.sv
// Shared types and helpers for the interrupt handshake controller and
// related event-unit blocks.
package irq_ctrl_pkg;

   localparam int NUM_IRQ_DEF  = 32;
   localparam int ID_WIDTH_DEF = 5;

   // Handshake sequencing states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_CLEAR = 2'd2,
      ST_GAP   = 2'd3
   } irq_state_e;

   // Expand an interrupt index into a 32-bit one-hot vector
   function automatic logic [31:0] id_to_onehot(input logic [31:0] idx);
      return 32'd1 << idx;
   endfunction

   // Lowest set bit of a one-hot (or any) vector, 0 when empty
   function automatic logic [31:0] onehot_to_id(input logic [31:0] vec);
      logic [31:0] res;
      res = '0;
      for (int i = 31; i >= 0; i--) begin
         if (vec[i]) res = 32'(i);
      end
      return res;
   endfunction

   // Lower index means higher priority
   function automatic logic is_higher_prio(input logic [31:0] a, input logic [31:0] b);
      return a < b;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder; lowest set request wins.
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_IRQ  = NUM_IRQ_DEF,
   parameter int ID_WIDTH = ID_WIDTH_DEF
) (
   input  logic [NUM_IRQ-1:0]  req,
   output logic [ID_WIDTH-1:0] sel,
   output logic                valid
);

   logic [NUM_IRQ-1:0] grant;

   // A line is granted only when no lower-indexed line is requesting
   generate
      for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_grant
         if (gi == 0) begin : g_first
            assign grant[gi] = req[gi];
         end else begin : g_rest
            assign grant[gi] = req[gi] & ~(|req[gi-1:0]);
         end
      end
   endgenerate

   assign valid = |req;

   // Encode the single granted line into its index
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (grant[i]) sel = sel | ID_WIDTH'(i);
      end
   end

endmodule

// File: rtl/irq_handshake_ctrl.sv
// Delivers the highest-priority pending interrupt to one core with a
// request/acknowledge handshake, a one-cycle clear pulse and an idle gap.
module irq_handshake_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_IRQ   = NUM_IRQ_DEF,
   parameter int ID_WIDTH  = ID_WIDTH_DEF,
   parameter int GAP_WIDTH = 4
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic [NUM_IRQ-1:0]   pending_i,
   input  logic [GAP_WIDTH-1:0] gap_cfg_i,
   input  logic                 core_sleeping_i,
   input  logic                 irq_ack_i,
   input  logic [ID_WIDTH-1:0]  irq_ack_id_i,
   output logic                 irq_req_o,
   output logic [ID_WIDTH-1:0]  irq_id_o,
   output logic [NUM_IRQ-1:0]   clear_o,
   output logic                 wake_o,
   output logic                 ack_err_o,
   output logic                 busy_o
);

   irq_state_e           state_reg;
   logic [ID_WIDTH-1:0]  id_reg;
   logic [GAP_WIDTH:0]   gap_cnt_reg;

   logic [ID_WIDTH-1:0]  sel;
   logic                 sel_valid;
   logic [31:0]          onehot_full;
   logic [NUM_IRQ-1:0]   onehot_cur;

   irq_prio_enc #(
      .NUM_IRQ  (NUM_IRQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_prio_enc (
      .req   (pending_i),
      .sel   (sel),
      .valid (sel_valid)
   );

   assign onehot_full = id_to_onehot(32'(id_reg));
   assign onehot_cur  = onehot_full[NUM_IRQ-1:0];

   // Handshake FSM; every output is registered alongside the state it belongs to
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_reg   <= ST_IDLE;
         id_reg      <= '0;
         gap_cnt_reg <= '0;
         irq_req_o   <= 1'b0;
         irq_id_o    <= '0;
         clear_o     <= '0;
         wake_o      <= 1'b0;
         ack_err_o   <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         clear_o   <= '0;
         ack_err_o <= 1'b0;
         wake_o    <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (sel_valid) begin
                  state_reg <= ST_REQ;
                  id_reg    <= sel;
                  irq_req_o <= 1'b1;
                  irq_id_o  <= sel;
                  wake_o    <= core_sleeping_i;
                  busy_o    <= 1'b1;
               end
            end
            ST_REQ: begin
               wake_o <= core_sleeping_i;
               if (irq_ack_i && (irq_ack_id_i == id_reg)) begin
                  // Ack takes precedence even if the line was just retracted
                  state_reg <= ST_CLEAR;
                  clear_o   <= onehot_cur;
                  irq_req_o <= 1'b0;
                  irq_id_o  <= '0;
                  wake_o    <= 1'b0;
               end else if (irq_ack_i) begin
                  ack_err_o <= 1'b1;
               end else if (!pending_i[id_reg]) begin
                  state_reg <= ST_IDLE;
                  irq_req_o <= 1'b0;
                  irq_id_o  <= '0;
                  wake_o    <= 1'b0;
                  busy_o    <= 1'b0;
               end else if (sel_valid && is_higher_prio(32'(sel), 32'(id_reg))) begin
                  id_reg   <= sel;
                  irq_id_o <= sel;
               end
            end
            ST_CLEAR: begin
               // Gap of gap_cfg+2 cycles hides the service unit's clear latency
               state_reg   <= ST_GAP;
               gap_cnt_reg <= {1'b0, gap_cfg_i} + {{GAP_WIDTH{1'b0}}, 1'b1};
            end
            ST_GAP: begin
               if (gap_cnt_reg == '0) begin
                  state_reg <= ST_IDLE;
                  busy_o    <= 1'b0;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - {{GAP_WIDTH{1'b0}}, 1'b1};
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               irq_req_o <= 1'b0;
               irq_id_o  <= '0;
               busy_o    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_handshake_ctrl.sv
// Self-checking bench: directed handshake scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_irq_handshake_ctrl;

   localparam int NUM_IRQ   = 32;
   localparam int ID_WIDTH  = 5;
   localparam int GAP_WIDTH = 4;

   logic                 HCLK = 1'b0;
   logic                 HRESET;
   logic [NUM_IRQ-1:0]   pending_i;
   logic [GAP_WIDTH-1:0] gap_cfg_i;
   logic                 core_sleeping_i;
   logic                 irq_ack_i;
   logic [ID_WIDTH-1:0]  irq_ack_id_i;
   logic                 irq_req_o;
   logic [ID_WIDTH-1:0]  irq_id_o;
   logic [NUM_IRQ-1:0]   clear_o;
   logic                 wake_o;
   logic                 ack_err_o;
   logic                 busy_o;

   irq_handshake_ctrl #(
      .NUM_IRQ   (NUM_IRQ),
      .ID_WIDTH  (ID_WIDTH),
      .GAP_WIDTH (GAP_WIDTH)
   ) dut (
      .HCLK            (HCLK),
      .HRESET          (HRESET),
      .pending_i       (pending_i),
      .gap_cfg_i       (gap_cfg_i),
      .core_sleeping_i (core_sleeping_i),
      .irq_ack_i       (irq_ack_i),
      .irq_ack_id_i    (irq_ack_id_i),
      .irq_req_o       (irq_req_o),
      .irq_id_o        (irq_id_o),
      .clear_o         (clear_o),
      .wake_o          (wake_o),
      .ack_err_o       (ack_err_o),
      .busy_o          (busy_o)
   );

   always #5 HCLK = ~HCLK;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: a delivery is either outstanding, being cleared,
   // or followed by a number of remaining hold-off cycles.
   bit          m_active;
   int          m_id;
   bit          m_clearing;
   int          m_hold;
   logic [31:0] exp_clear;
   bit          exp_err;
   bit          exp_wake;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest_pending(input logic [31:0] v);
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // Advance the model by one clock edge using the inputs present at that edge
   task automatic model_step();
      exp_clear = '0;
      exp_err   = 1'b0;
      if (HRESET) begin
         m_active   = 1'b0;
         m_clearing = 1'b0;
         m_hold     = 0;
         m_id       = 0;
      end else if (m_clearing) begin
         m_clearing = 1'b0;
         m_hold     = int'(gap_cfg_i) + 2;
      end else if (m_hold > 0) begin
         m_hold--;
      end else if (m_active) begin
         if (irq_ack_i && int'(irq_ack_id_i) == m_id) begin
            m_active   = 1'b0;
            m_clearing = 1'b1;
            exp_clear  = 32'd1 << m_id;
         end else if (irq_ack_i) begin
            exp_err = 1'b1;
         end else if (!pending_i[m_id]) begin
            m_active = 1'b0;
         end else if (lowest_pending(pending_i) < m_id) begin
            m_id = lowest_pending(pending_i);
         end
      end else if (pending_i != '0) begin
         m_active = 1'b1;
         m_id     = lowest_pending(pending_i);
      end
      exp_wake = m_active && core_sleeping_i;
   endtask

   // One clock: update model at the edge, then compare every output
   task automatic step();
      @(posedge HCLK);
      model_step();
      #1;
      check_val("req",   32'(irq_req_o), 32'(m_active));
      check_val("id",    32'(irq_id_o),  m_active ? 32'(m_id) : 32'd0);
      check_val("clear", 32'(clear_o),   exp_clear);
      check_val("wake",  32'(wake_o),    32'(exp_wake));
      check_val("err",   32'(ack_err_o), 32'(exp_err));
      check_val("busy",  32'(busy_o),    32'(m_active || m_clearing || m_hold > 0));
      $display("cyc t=%0t rst=%0b pend=%h ack=%0b/%0d req=%0b id=%0d clr=%h wake=%0b err=%0b busy=%0b",
               $time, HRESET, pending_i, irq_ack_i, irq_ack_id_i, irq_req_o, irq_id_o,
               clear_o, wake_o, ack_err_o, busy_o);
   endtask

   task automatic drain();
      pending_i = '0;
      irq_ack_i = 1'b0;
      for (int i = 0; i < 20; i++) step();
   endtask

   initial begin
      HRESET          = 1'b1;
      pending_i       = '0;
      gap_cfg_i       = '0;
      core_sleeping_i = 1'b0;
      irq_ack_i       = 1'b0;
      irq_ack_id_i    = '0;
      m_active = 0; m_id = 0; m_clearing = 0; m_hold = 0;
      step();
      step();
      check_val("reset_busy", 32'(busy_o), 32'd0);
      HRESET = 1'b0;
      step();

      // Basic delivery, gap 0
      pending_i = 32'h0000_0010;
      step();
      check_val("tp1_id", 32'(irq_id_o), 32'd4);
      irq_ack_i = 1'b1; irq_ack_id_i = 5'd4;
      step();
      check_val("tp1_clear", clear_o, 32'h10);
      irq_ack_i = 1'b0; pending_i = '0;
      step(); step(); step();
      check_val("tp1_busy_drop", 32'(busy_o), 32'd0);

      // Higher-priority arrival while requesting
      pending_i = 32'h0000_0100;
      step();
      pending_i = 32'h0000_0104;
      step();
      check_val("tp2_switch", 32'(irq_id_o), 32'd2);
      irq_ack_i = 1'b1; irq_ack_id_i = 5'd2;
      step();
      check_val("tp2_clear", clear_o, 32'h4);
      drain();

      // Mismatched acknowledge
      pending_i = 32'h0000_0020;
      step();
      irq_ack_i = 1'b1; irq_ack_id_i = 5'd6;
      step();
      check_val("tp3_err", 32'(ack_err_o), 32'd1);
      irq_ack_id_i = 5'd5;
      step();
      check_val("tp3_clear", clear_o, 32'h20);
      drain();

      // Retraction, then simultaneous ack and retraction
      pending_i = 32'h0000_0008;
      step();
      pending_i = '0;
      step();
      check_val("tp4_retract", 32'(irq_req_o), 32'd0);
      pending_i = 32'h0000_0008;
      step();
      pending_i = '0; irq_ack_i = 1'b1; irq_ack_id_i = 5'd3;
      step();
      check_val("tp4_ack_wins", clear_o, 32'h8);
      drain();

      // Wake while the core sleeps
      core_sleeping_i = 1'b1; pending_i = 32'h1;
      step();
      check_val("tp5_wake", 32'(wake_o), 32'd1);
      core_sleeping_i = 1'b0;
      step();
      check_val("tp5_wake_off", 32'(wake_o), 32'd0);
      drain();

      // Reset mid-REQ and mid-GAP
      gap_cfg_i = 4'd15; pending_i = 32'h2;
      step(); step();
      HRESET = 1'b1;
      step();
      check_val("tp6_rst_req", 32'(irq_req_o), 32'd0);
      HRESET = 1'b0;
      step();
      check_val("tp6_reissue", 32'(irq_req_o), 32'd1);
      irq_ack_i = 1'b1; irq_ack_id_i = 5'd1;
      step();
      irq_ack_i = 1'b0;
      step(); step(); step();
      HRESET = 1'b1;
      step();
      check_val("tp6_rst_gap", 32'(busy_o), 32'd0);
      HRESET = 1'b0;
      step();
      check_val("tp6_reissue2", 32'(irq_id_o), 32'd1);
      drain();
      gap_cfg_i = 4'd0;

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         int r;
         int idx;
         HRESET = ($urandom_range(0, 299) == 0);
         if (n % 500 == 0) gap_cfg_i = GAP_WIDTH'($urandom_range(0, 5));
         r = $urandom_range(0, 99);
         idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
         if (r < 12) pending_i[idx] = 1'b1;
         else if (r < 16) pending_i[idx] = 1'b0;
         pending_i = pending_i & ~exp_clear;
         if ($urandom_range(0, 9) == 0) core_sleeping_i = ~core_sleeping_i;
         r = $urandom_range(0, 99);
         if ((m_active && r < 30) || r < 4) begin
            irq_ack_i    = 1'b1;
            irq_ack_id_i = ($urandom_range(0, 4) != 0) ? ID_WIDTH'(m_id)
                                                        : ID_WIDTH'($urandom_range(0, 31));
         end else begin
            irq_ack_i    = 1'b0;
            irq_ack_id_i = ID_WIDTH'($urandom_range(0, 31));
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
